// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI slave clocked entirely by clk. sck, ss_L and mosi
// are oversampled through 2-flop synchronizers, and edges are detected from
// the synchronized copies.
// Each transaction shifts to_master out on miso MSB-first and captures the
// master's mosi word into from_master. CPOL and CPHA are chosen by the
// POLARITY and PHASE parameters.
// Optional build macro SPI_SLAVE_RESPONDER_ARM_EN adds the arm input. When
// arm is low at the ss_L fall, the slave returns zeros and the transaction
// ends with err instead of finished.
//
// state | meaning
// IDLE  | waiting for ss_L fall; miso driven low, sck/mosi ignored
// XFER  | ss_L asserted; sample/shift on sck edges, count received bits
// DONE  | ss_L released; publish rx word or flag error, then back to IDLE

module spi_slave_responder #(
  parameter int WID      = 24,
  parameter int WID_LEN  = 5,
  parameter bit POLARITY = 1'b0,
  parameter bit PHASE    = 1'b0
) (
  input  logic           clk,
  input  logic           rst_L,
  input  logic           sck,
  input  logic           ss_L,
  input  logic           mosi,
`ifdef SPI_SLAVE_RESPONDER_ARM_EN
  input  logic           arm,
`endif
  input  logic [WID-1:0] to_master,
  output logic           miso,
  output logic [WID-1:0] from_master,
  output logic           finished,
  output logic           err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WID_LEN-1:0] CNT_ONE  = WID_LEN'(1);
  localparam logic [WID_LEN-1:0] CNT_FULL = WID_LEN'(WID);
  localparam logic [WID_LEN-1:0] CNT_OVR  = WID_LEN'(WID + 1);

  logic sck_s1_q, sck_s2_q, sck_dly_q;
  logic ss_s1_q, ss_s2_q, ss_dly_q;
  logic mosi_s1_q, mosi_s2_q;

  state_e             state_q, state_d;
  logic [WID-1:0]     tx_q, tx_d;
  logic [WID-1:0]     rx_q, rx_d;
  logic [WID_LEN-1:0] cnt_q, cnt_d;
  logic               miso_q, miso_d;
  logic [WID-1:0]     fm_q, fm_d;
  logic               fin_q, fin_d;
  logic               err_q, err_d;
  logic               armed_q, armed_d;
  logic               pend_q, pend_d;

  logic           sck_edge, sck_lead, sck_trail;
  logic           sample_edge, shift_edge;
  logic           ss_fall, ss_rise;
  logic           arm_now;
  logic [WID-1:0] load_word;

  // Synchronize the asynchronous SPI pins and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      sck_s1_q  <= POLARITY;
      sck_s2_q  <= POLARITY;
      sck_dly_q <= POLARITY;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_dly_q  <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= sck;
      sck_s2_q  <= sck_s1_q;
      sck_dly_q <= sck_s2_q;
      ss_s1_q   <= ss_L;
      ss_s2_q   <= ss_s1_q;
      ss_dly_q  <= ss_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // Classify edges. Leading means sck leaves its idle level.
  always_comb begin
    sck_edge    = sck_s2_q ^ sck_dly_q;
    sck_lead    = sck_edge && (sck_s2_q != POLARITY);
    sck_trail   = sck_edge && (sck_s2_q == POLARITY);
    sample_edge = PHASE ? sck_trail : sck_lead;
    shift_edge  = PHASE ? sck_lead  : sck_trail;
    ss_fall     = ss_dly_q & ~ss_s2_q;
    ss_rise     = ~ss_dly_q & ss_s2_q;
  end

  // Arm qualification. Without the feature every transaction is armed.
`ifdef SPI_SLAVE_RESPONDER_ARM_EN
  assign arm_now = arm;
`else
  assign arm_now = 1'b1;
`endif
  assign load_word = arm_now ? to_master : '0;

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      fm_q    <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      fm_q    <= fm_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and datapath logic. Within one cycle a sample edge is applied
  // before an ss_L rise, so a final bit that coincides with the rise is kept.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    fm_d    = fm_q;
    fin_d   = 1'b0;
    err_d   = 1'b0;
    armed_d = armed_q;
    pend_d  = pend_q;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall || pend_q) begin
          pend_d  = 1'b0;
          armed_d = arm_now;
          rx_d    = '0;
          cnt_d   = '0;
          state_d = S_XFER;
          if (!PHASE) begin
            // CPHA=0: the MSB has to be on miso before the first leading edge.
            miso_d = load_word[WID-1];
            tx_d   = load_word << 1;
          end else begin
            tx_d = load_word;
          end
        end
      end

      S_XFER: begin
        if (sample_edge) begin
          if (cnt_q == CNT_FULL) begin
            cnt_d = CNT_OVR;
          end else if (cnt_q < CNT_FULL) begin
            rx_d  = {rx_q[WID-2:0], mosi_s2_q};
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        // Stop shifting once WID bits have been sampled; for CPHA=0 this makes
        // miso hold its last bit on the trailing edge after the final sample.
        if (shift_edge && (cnt_q < CNT_FULL)) begin
          miso_d = tx_q[WID-1];
          tx_d   = tx_q << 1;
        end
        if (ss_rise) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        miso_d  = 1'b0;
        state_d = S_IDLE;
        if (cnt_q == CNT_FULL) begin
          fm_d = rx_q;
        end
        if ((cnt_q == CNT_FULL) && armed_q) begin
          fin_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        // A select that falls again right away is remembered for IDLE.
        if (ss_fall) begin
          pend_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  assign miso        = miso_q;
  assign from_master = fm_q;
  assign finished    = fin_q;
  assign err         = err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder. Two instances run side by side: one in
// mode 0 (CPOL=0, CPHA=0) and one in mode 3 (CPOL=1, CPHA=1). A bit-level SPI
// master drives whichever instance is selected. Expected read words, latched
// words and pulse counts come from a word-level model of the transaction.

module tb_spi_slave_responder;

  localparam int WID = 24;
  localparam int H   = 5;

  logic clk = 1'b0;
  logic rst_L;
  int   sel;
  logic m_sck, m_ss, m_mosi;
  logic arm;

  logic sck0, ss0, mosi0, sck1, ss1, mosi1;
  logic [WID-1:0] tm0, tm1;
  logic miso0, miso1, fin0, fin1, err0, err1;
  logic [WID-1:0] fm0, fm1;

  int n_cmp = 0;
  int n_bad = 0;
  int fin_c0 = 0, fin_c1 = 0, err_c0 = 0, err_c1 = 0, both_c = 0;
  logic [WID-1:0] exp_fm [2];

  always #5 clk = ~clk;

  assign sck0  = (sel == 0) ? m_sck  : 1'b0;
  assign ss0   = (sel == 0) ? m_ss   : 1'b1;
  assign mosi0 = (sel == 0) ? m_mosi : 1'b0;
  assign sck1  = (sel == 1) ? m_sck  : 1'b1;
  assign ss1   = (sel == 1) ? m_ss   : 1'b1;
  assign mosi1 = (sel == 1) ? m_mosi : 1'b0;

  spi_slave_responder #(.WID(WID), .WID_LEN(5), .POLARITY(1'b0), .PHASE(1'b0)) u_dut0 (
    .clk(clk), .rst_L(rst_L), .sck(sck0), .ss_L(ss0), .mosi(mosi0),
`ifdef SPI_SLAVE_RESPONDER_ARM_EN
    .arm(arm),
`endif
    .to_master(tm0), .miso(miso0), .from_master(fm0), .finished(fin0), .err(err0)
  );

  spi_slave_responder #(.WID(WID), .WID_LEN(5), .POLARITY(1'b1), .PHASE(1'b1)) u_dut1 (
    .clk(clk), .rst_L(rst_L), .sck(sck1), .ss_L(ss1), .mosi(mosi1),
`ifdef SPI_SLAVE_RESPONDER_ARM_EN
    .arm(arm),
`endif
    .to_master(tm1), .miso(miso1), .from_master(fm1), .finished(fin1), .err(err1)
  );

  always @(posedge clk) begin
    if (fin0) fin_c0++;
    if (fin1) fin_c1++;
    if (err0) err_c0++;
    if (err1) err_c1++;
    if ((fin0 && err0) || (fin1 && err1)) both_c++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic miso_of(input int d);
    return (d == 1) ? miso1 : miso0;
  endfunction

  task automatic set_sel(input int d);
    m_ss   = 1'b1;
    m_mosi = 1'b0;
    m_sck  = (d == 1);
    sel    = d;
    tick(8);
  endtask

  // Bit-level SPI master for the selected instance's mode.
  task automatic spi_run(input int d, input int nbits, input logic [WID-1:0] word,
                         input logic fill, input bit raise_ss, output logic [WID-1:0] rd);
    logic pol, pha, b, nb;
    pol = (d == 1);
    pha = (d == 1);
    rd  = '0;
    m_ss = 1'b0;
    if (!pha) m_mosi = word[WID-1];
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      b  = (i < WID) ? word[WID-1-i] : fill;
      nb = (i + 1 < WID) ? word[WID-2-i] : fill;
      if (!pha && i < WID) rd[WID-1-i] = miso_of(d);
      m_sck = ~pol;
      if (pha) m_mosi = b;
      tick(H);
      if (pha && i < WID) rd[WID-1-i] = miso_of(d);
      m_sck = pol;
      if (!pha) m_mosi = nb;
      tick(H);
    end
    if (raise_ss) begin
      m_ss   = 1'b1;
      m_mosi = 1'b0;
      tick(H);
    end
  endtask

  // One complete transaction checked against the word-level model.
  task automatic do_xfer(input int d, input int n, input logic [WID-1:0] tmw,
                         input logic [WID-1:0] mw, input logic fill, input logic armv);
    logic [WID-1:0] rd, exp_rd;
    logic [63:0]    m64;
    logic           armed, good;
    int             nn, f_before, e_before;
    if (d == 0) tm0 = tmw; else tm1 = tmw;
`ifdef SPI_SLAVE_RESPONDER_ARM_EN
    arm   = armv;
    armed = armv;
`else
    armed = 1'b1 | armv;
`endif
    f_before = (d == 1) ? fin_c1 : fin_c0;
    e_before = (d == 1) ? err_c1 : err_c0;
    spi_run(d, n, mw, fill, 1'b1, rd);
    tmw = ~tmw;
    if (d == 0) tm0 = tmw; else tm1 = tmw;
    tick(6);
    tmw = ~tmw;
    nn     = (n > WID) ? WID : n;
    m64    = ((64'd1 << nn) - 64'd1) << (WID - nn);
    exp_rd = armed ? (tmw & m64[WID-1:0]) : '0;
    good   = (n == WID);
    if (good) exp_fm[d] = mw;
    check($sformatf("d%0d n%0d master_read", d, n), 32'(rd), 32'(exp_rd));
    check($sformatf("d%0d n%0d from_master", d, n), 32'((d == 1) ? fm1 : fm0), 32'(exp_fm[d]));
    check($sformatf("d%0d n%0d finished_cnt", d, n),
          32'(((d == 1) ? fin_c1 : fin_c0) - f_before), 32'((good && armed) ? 1 : 0));
    check($sformatf("d%0d n%0d err_cnt", d, n),
          32'(((d == 1) ? err_c1 : err_c0) - e_before), 32'((good && armed) ? 0 : 1));
    check($sformatf("d%0d n%0d miso_idle", d, n), 32'(miso_of(d)), 32'(0));
`ifdef SPI_SLAVE_RESPONDER_ARM_EN
    arm = 1'b1;
`endif
  endtask

  initial begin
    logic [WID-1:0] rd, w, saved;
    int d, r, n, f0, e0, f1, e1;

    rst_L  = 1'b0;
    sel    = 0;
    m_sck  = 1'b0;
    m_ss   = 1'b1;
    m_mosi = 1'b0;
    arm    = 1'b1;
    tm0    = '0;
    tm1    = '0;
    exp_fm[0] = '0;
    exp_fm[1] = '0;
    tick(3);
    check("reset miso0", 32'(miso0), 32'(0));
    check("reset fm0", 32'(fm0), 32'(0));
    check("reset fin0", 32'(fin0), 32'(0));
    check("reset err0", 32'(err0), 32'(0));
    check("reset miso1", 32'(miso1), 32'(0));
    check("reset fm1", 32'(fm1), 32'(0));
    rst_L = 1'b1;
    tick(4);

    // Mode 0 and mode 3 basic transfers.
    do_xfer(0, WID, 24'hA5C3F0, 24'h123456, 1'b0, 1'b1);
    set_sel(1);
    do_xfer(1, WID, 24'hA5C3F0, 24'h123456, 1'b0, 1'b1);

    // Mode 3 with ss_L held high: sck and mosi activity must be ignored.
    f1 = fin_c1;
    e1 = err_c1;
    for (int i = 0; i < 40; i++) begin
      m_sck  = ~m_sck;
      m_mosi = 1'($urandom);
      tick(2);
    end
    m_sck = 1'b1;
    tick(6);
    check("noise fm1", 32'(fm1), 32'(exp_fm[1]));
    check("noise fin1", 32'(fin_c1 - f1), 32'(0));
    check("noise err1", 32'(err_c1 - e1), 32'(0));

    // Short and overrun transactions on mode 0, then a clean one.
    set_sel(0);
    do_xfer(0, WID - 1, 24'hA5C3F0, 24'($urandom), 1'b0, 1'b1);
    do_xfer(0, WID + 1, 24'h3C3C3C, 24'hFFFFFF, 1'b1, 1'b1);
    do_xfer(0, WID, 24'h5A5A5A, 24'h00000F, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a mode 0 transfer.
    tm0 = 24'h777777;
    spi_run(0, 12, 24'hABCDEF, 1'b0, 1'b0, rd);
    rst_L = 1'b0;
    #1;
    check("rst_mid miso0", 32'(miso0), 32'(0));
    check("rst_mid fm0", 32'(fm0), 32'(0));
    check("rst_mid fin0", 32'(fin0), 32'(0));
    check("rst_mid err0", 32'(err0), 32'(0));
    check("rst_mid fm1", 32'(fm1), 32'(0));
    exp_fm[0] = '0;
    exp_fm[1] = '0;
    m_ss   = 1'b1;
    m_sck  = 1'b0;
    m_mosi = 1'b0;
    tick(3);
    f0 = fin_c0;
    e0 = err_c0;
    f1 = fin_c1;
    e1 = err_c1;
    rst_L = 1'b1;
    tick(12);
    check("rst_rel pulses0", 32'((fin_c0 - f0) + (err_c0 - e0)), 32'(0));
    check("rst_rel pulses1", 32'((fin_c1 - f1) + (err_c1 - e1)), 32'(0));
    check("rst_rel fm0", 32'(fm0), 32'(0));
    do_xfer(0, WID, 24'h0F1E2D, 24'hFFFFFF, 1'b0, 1'b1);

`ifdef SPI_SLAVE_RESPONDER_ARM_EN
    do_xfer(0, WID, 24'hFFFFFF, 24'h81C3E7, 1'b0, 1'b0);
    do_xfer(0, WID, 24'hFFFFFF, 24'h42A5DB, 1'b0, 1'b1);
    set_sel(1);
    do_xfer(1, WID, 24'hFFFFFF, 24'h1248C0, 1'b0, 1'b0);
`endif

    // Randomized transactions across both modes.
    for (int k = 0; k < 12; k++) begin
      d = int'($urandom_range(1, 0));
      if (d != sel) set_sel(d);
      r = int'($urandom_range(5, 0));
      n = (r == 0) ? int'($urandom_range(WID - 1, 1)) : (r == 1) ? WID + 1 : WID;
      w = 24'($urandom);
      saved = 24'($urandom);
      do_xfer(d, n, w, saved, 1'($urandom), 1'b1);
    end

    check("never finished and err together", 32'(both_c), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
